// File: rtl/coeff_ram_loader.sv
// Coefficient RAM loader: takes 1..40 FIR taps over a valid/ready port and
// writes all 40 RAM slots, zero-filling the slots beyond the last tap received.
module coeff_ram_loader (
  input  logic        iClk12M,
  input  logic        iRst,
  input  logic        iStart,
  input  logic [5:0]  iTapCnt,
  input  logic        iCoeffValid,
  input  logic [15:0] iCoeffData,
  output logic        oCoeffReady,
  output logic        oCoeffUpdateFlag,
  output logic        oCsnRam,
  output logic        oWrnRam,
  output logic [5:0]  oAddrRam,
  output logic [15:0] oWrDtRam,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    WRITE,
    RELEASE,
    ZFILL,
    DONE
  } loaderState;

  loaderState state;
  logic [5:0] tapCnt;
  logic [5:0] index;

  // Taps are packed ten per 16-word RAM bank.
  function automatic logic [5:0] mapAddr(input logic [5:0] idx);
    if (idx < 6'd10)
      return idx;
    else if (idx < 6'd20)
      return idx + 6'd6;
    else if (idx < 6'd30)
      return idx + 6'd12;
    else
      return idx + 6'd18;
  endfunction

  // All outputs are set on the edge that enters the state they belong to.
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state            <= IDLE;
      tapCnt           <= 6'd0;
      index            <= 6'd0;
      oCoeffReady      <= 1'b0;
      oCoeffUpdateFlag <= 1'b0;
      oCsnRam          <= 1'b1;
      oWrnRam          <= 1'b1;
      oAddrRam         <= 6'd0;
      oWrDtRam         <= 16'd0;
      oBusy            <= 1'b0;
      oDone            <= 1'b0;
      oErr             <= 1'b0;
    end else begin
      oDone <= 1'b0;
      oErr  <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            if (iTapCnt >= 6'd1 && iTapCnt <= 6'd40) begin
              state            <= WAIT_DATA;
              tapCnt           <= iTapCnt;
              index            <= 6'd0;
              oCoeffReady      <= 1'b1;
              oCoeffUpdateFlag <= 1'b1;
              oBusy            <= 1'b1;
            end else begin
              oErr <= 1'b1;
            end
          end
        end
        WAIT_DATA: begin
          if (iCoeffValid) begin
            state       <= WRITE;
            oCoeffReady <= 1'b0;
            oWrDtRam    <= iCoeffData;
            oAddrRam    <= mapAddr(index);
            oCsnRam     <= 1'b0;
            oWrnRam     <= 1'b0;
          end
        end
        WRITE, ZFILL: begin
          state   <= RELEASE;
          oCsnRam <= 1'b1;
          oWrnRam <= 1'b1;
        end
        RELEASE: begin
          // Past the last supplied tap every remaining index is a zero write.
          if (index < tapCnt - 6'd1) begin
            state       <= WAIT_DATA;
            index       <= index + 6'd1;
            oCoeffReady <= 1'b1;
          end else if (index < 6'd39) begin
            state    <= ZFILL;
            index    <= index + 6'd1;
            oWrDtRam <= 16'd0;
            oAddrRam <= mapAddr(index + 6'd1);
            oCsnRam  <= 1'b0;
            oWrnRam  <= 1'b0;
          end else begin
            state            <= DONE;
            oDone            <= 1'b1;
            oCoeffUpdateFlag <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coeff_ram_loader.sv
// Self-checking bench for coeff_ram_loader: table vectors, random loads and
// hand-written corner sequences, all checked against a tap-level RAM model.
module tb_coeff_ram_loader;

  logic        iClk12M = 1'b0;
  logic        iRst;
  logic        iStart;
  logic [5:0]  iTapCnt;
  logic        iCoeffValid;
  logic [15:0] iCoeffData;
  logic        oCoeffReady;
  logic        oCoeffUpdateFlag;
  logic        oCsnRam;
  logic        oWrnRam;
  logic [5:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic        oBusy;
  logic        oDone;
  logic        oErr;

  coeff_ram_loader dut (
    .iClk12M         (iClk12M),
    .iRst            (iRst),
    .iStart          (iStart),
    .iTapCnt         (iTapCnt),
    .iCoeffValid     (iCoeffValid),
    .iCoeffData      (iCoeffData),
    .oCoeffReady     (oCoeffReady),
    .oCoeffUpdateFlag(oCoeffUpdateFlag),
    .oCsnRam         (oCsnRam),
    .oWrnRam         (oWrnRam),
    .oAddrRam        (oAddrRam),
    .oWrDtRam        (oWrDtRam),
    .oBusy           (oBusy),
    .oDone           (oDone),
    .oErr            (oErr)
  );

  always #42 iClk12M = ~iClk12M;

  typedef struct {
    int tapCnt;
    bit validRand;
    bit expErr;
    int expCycles;
  } vecT;

  vecT vecs[10];

  int checks = 0;
  int errors = 0;
  int curTap = 0;
  int lastBase = 0;
  logic [15:0] words[40];

  int cyc = 0;
  int doneCnt = 0;
  int errCnt = 0;
  int hsViol = 0;
  int pulseViol = 0;
  int firstReadyCyc = 0;
  int doneCyc = 0;
  int wIdx = 0;
  logic prevHs = 1'b0;
  logic prevWrite = 1'b0;
  logic prevBusy = 1'b0;
  logic [5:0]  wlogAddr[$];
  logic [15:0] wlogData[$];

  // Bus observer: logs every RAM write and flags strobes that are too long
  // or data writes that had no accepted handshake in the cycle before.
  always @(negedge iClk12M) begin
    cyc <= cyc + 1;
    if (oDone === 1'b1) begin
      doneCnt <= doneCnt + 1;
      doneCyc <= cyc;
    end
    if (oErr === 1'b1)
      errCnt <= errCnt + 1;
    if (oBusy === 1'b1 && prevBusy !== 1'b1) begin
      firstReadyCyc <= cyc;
      wIdx <= 0;
    end else if (oCsnRam === 1'b0 && oWrnRam === 1'b0) begin
      wlogAddr.push_back(oAddrRam);
      wlogData.push_back(oWrDtRam);
      if (prevWrite)
        pulseViol <= pulseViol + 1;
      if (wIdx < curTap && !prevHs)
        hsViol <= hsViol + 1;
      wIdx <= wIdx + 1;
    end
    prevWrite <= (oCsnRam === 1'b0 && oWrnRam === 1'b0);
    prevHs    <= (iCoeffValid === 1'b1 && oCoeffReady === 1'b1);
    prevBusy  <= (oBusy === 1'b1);
  end

  function automatic int refAddr(input int i);
    return 16 * (i / 10) + (i % 10);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string name);
    checkOutput(name,
      {3'd0, oCoeffReady, oCoeffUpdateFlag, oCsnRam, oWrnRam, oAddrRam, oWrDtRam, oBusy, oDone, oErr},
      {3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 16'd0, 1'b0, 1'b0, 1'b0});
  endtask

  task automatic applyStimulus(input logic start, input logic [5:0] tap);
    @(posedge iClk12M); #1;
    iStart  = start;
    iTapCnt = tap;
    @(posedge iClk12M); #1;
    iStart = 1'b0;
  endtask

  task automatic runErr(input int tap, input string tag);
    int eb;
    @(posedge iClk12M); #1;
    eb = errCnt;
    applyStimulus(1'b1, 6'(tap));
    @(negedge iClk12M);
    checkOutput({tag, "_errPulse"}, 32'(oErr), 32'd1);
    checkOutput({tag, "_busyLow"}, 32'(oBusy), 32'd0);
    checkOutput({tag, "_csnHigh"}, 32'(oCsnRam), 32'd1);
    checkOutput({tag, "_flagLow"}, 32'(oCoeffUpdateFlag), 32'd0);
    @(negedge iClk12M);
    checkOutput({tag, "_errCleared"}, 32'(oErr), 32'd0);
    repeat (3) @(negedge iClk12M);
    checkOutput({tag, "_stillIdle"}, 32'({oBusy, oCsnRam}), 32'b01);
    checkOutput({tag, "_errCount"}, 32'(errCnt - eb), 32'd1);
  endtask

  task automatic runLoad(input int n, input bit randValid, input bit pokeStart,
                         input bit forceFirst, input int expCycles, input string tag);
    int base, doneBase, errBase, hsBase, pvBase, k, guard, seqErr, firstBad;
    bit hs, poked, pokeZ;
    for (int i = 0; i < 40; i++)
      words[i] = (i < n) ? 16'($urandom) : 16'd0;
    if (forceFirst)
      words[0] = 16'hEF0E;
    curTap = n;
    @(posedge iClk12M); #1;
    base     = wlogAddr.size();
    doneBase = doneCnt;
    errBase  = errCnt;
    hsBase   = hsViol;
    pvBase   = pulseViol;
    lastBase = base;
    applyStimulus(1'b1, 6'(n));

    k = 0;
    guard = 0;
    poked = 1'b0;
    while (k < n && guard < 5000) begin
      iCoeffValid = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
      iCoeffData  = iCoeffValid ? words[k] : 16'($urandom);
      @(negedge iClk12M);
      hs = iCoeffValid && oCoeffReady;
      if (pokeStart && !poked && k == 5 && oCoeffReady) begin
        iStart  = 1'b1;
        iTapCnt = 6'd7;
        poked   = 1'b1;
      end
      @(posedge iClk12M); #1;
      iStart = 1'b0;
      if (hs)
        k++;
      guard++;
    end
    iCoeffValid = 1'b0;
    checkOutput({tag, "_feedDone"}, 32'(k), 32'(n));

    if (pokeStart) begin
      pokeZ = 1'b0;
      for (int g = 0; g < 200 && !pokeZ; g++) begin
        @(negedge iClk12M);
        if (oCsnRam == 1'b0 && 32'(oAddrRam) == 32'(refAddr(n + 2))) begin
          iStart  = 1'b1;
          iTapCnt = 6'd3;
          pokeZ   = 1'b1;
          @(posedge iClk12M); #1;
          iStart = 1'b0;
        end
      end
      checkOutput({tag, "_pokeWaitDone"}, 32'(poked), 32'd1);
      checkOutput({tag, "_pokeZfillDone"}, 32'(pokeZ), 32'd1);
    end

    guard = 0;
    while (doneCnt == doneBase && guard < 400) begin
      @(negedge iClk12M);
      guard++;
    end
    repeat (4) @(negedge iClk12M);

    seqErr = 0;
    firstBad = -1;
    for (int i = 0; i < 40; i++) begin
      if (base + i >= wlogAddr.size() ||
          32'(wlogAddr[base + i]) != 32'(refAddr(i)) ||
          wlogData[base + i] !== words[i]) begin
        seqErr++;
        if (firstBad < 0)
          firstBad = i;
      end
    end
    if (seqErr != 0)
      $display("[TB] %s: first bad write index %0d", tag, firstBad);
    checkOutput({tag, "_doneOnce"}, 32'(doneCnt - doneBase), 32'd1);
    checkOutput({tag, "_writeCount"}, 32'(wlogAddr.size() - base), 32'd40);
    checkOutput({tag, "_writeSeq"}, 32'(seqErr), 32'd0);
    checkOutput({tag, "_noWriteWithoutValid"}, 32'(hsViol - hsBase), 32'd0);
    checkOutput({tag, "_strobeOneCycle"}, 32'(pulseViol - pvBase), 32'd0);
    checkOutput({tag, "_noErr"}, 32'(errCnt - errBase), 32'd0);
    checkOutput({tag, "_idleAfter"}, 32'({oBusy, oCoeffUpdateFlag, oCsnRam}), 32'b001);
    if (expCycles >= 0)
      checkOutput({tag, "_cycles"}, 32'(doneCyc - firstReadyCyc), 32'(expCycles));
  endtask

  initial begin
    #(84 * 60000);
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    int n;
    bit hs;
    bit found;
    bit rv;

    vecs[0] = '{0, 1'b0, 1'b1, 0};
    vecs[1] = '{41, 1'b0, 1'b1, 0};
    vecs[2] = '{63, 1'b0, 1'b1, 0};
    vecs[3] = '{33, 1'b0, 1'b0, 113};
    vecs[4] = '{40, 1'b1, 1'b0, -1};
    vecs[5] = '{1, 1'b0, 1'b0, 81};
    vecs[6] = '{10, 1'b0, 1'b0, 90};
    vecs[7] = '{39, 1'b1, 1'b0, -1};
    vecs[8] = '{40, 1'b0, 1'b0, 120};
    vecs[9] = '{17, 1'b1, 1'b0, -1};

    iRst        = 1'b1;
    iStart      = 1'b0;
    iTapCnt     = 6'd0;
    iCoeffValid = 1'b0;
    iCoeffData  = 16'd0;
    repeat (3) @(posedge iClk12M);
    @(negedge iClk12M);
    checkResetState("resetState");
    @(posedge iClk12M); #1;
    iRst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].expErr)
        runErr(vecs[i].tapCnt, $sformatf("vec%0d_tap%0d", i, vecs[i].tapCnt));
      else
        runLoad(vecs[i].tapCnt, vecs[i].validRand, 1'b0, 1'b0, vecs[i].expCycles,
                $sformatf("vec%0d_tap%0d", i, vecs[i].tapCnt));
    end

    runLoad(33, 1'b0, 1'b0, 1'b0, 113, "tap33");
    checkOutput("tap33_addrIdx16", 32'(wlogAddr[lastBase + 16]), 32'd22);
    checkOutput("tap33_addrIdx32", 32'(wlogAddr[lastBase + 32]), 32'd50);
    checkOutput("tap33_firstZeroAddr", 32'(wlogAddr[lastBase + 33]), 32'd51);
    checkOutput("tap33_firstZeroData", 32'(wlogData[lastBase + 33]), 32'd0);
    checkOutput("tap33_lastAddr", 32'(wlogAddr[lastBase + 39]), 32'd57);

    runLoad(5, 1'b0, 1'b0, 1'b1, 85, "negWord");
    checkOutput("negWord_data", 32'(wlogData[lastBase]), 32'h0000EF0E);
    checkOutput("negWord_addr", 32'(wlogAddr[lastBase]), 32'd0);

    runLoad(20, 1'b0, 1'b1, 1'b0, 100, "ignoreStart");

    // Reset landing in the WRITE cycle of index 12 (address 18).
    curTap = 40;
    for (int i = 0; i < 40; i++)
      words[i] = 16'($urandom);
    @(posedge iClk12M); #1;
    applyStimulus(1'b1, 6'd40);
    iCoeffValid = 1'b1;
    k = 0;
    found = 1'b0;
    for (int g = 0; g < 300 && !found; g++) begin
      iCoeffData = words[k];
      @(negedge iClk12M);
      if (oCsnRam == 1'b0 && oAddrRam == 6'd18) begin
        found = 1'b1;
      end else begin
        hs = iCoeffValid && oCoeffReady;
        @(posedge iClk12M); #1;
        if (hs && k < 39)
          k++;
      end
    end
    checkOutput("rst_reachedWrite12", 32'(found), 32'd1);
    iRst = 1'b1;
    @(posedge iClk12M); #1;
    iRst = 1'b0;
    iCoeffValid = 1'b0;
    @(negedge iClk12M);
    checkResetState("rst_midWriteState");
    repeat (3) @(negedge iClk12M);
    checkOutput("rst_noResume", 32'({oBusy, oCsnRam, oCoeffReady}), 32'b010);
    runLoad(40, 1'b0, 1'b0, 1'b0, 120, "afterRst");

    for (int r = 0; r < 6; r++) begin
      n  = $urandom_range(1, 40);
      rv = 1'($urandom_range(0, 1));
      runLoad(n, rv, 1'b0, 1'b0, rv ? -1 : 3 * n + 2 * (40 - n),
              $sformatf("rand%0d_tap%0d", r, n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coeff_ram_loader.md
COEFF_RAM_LOADER -- requirements
Module: coeff_ram_loader

Interface
REQ-001 The block SHALL have the port iClk12M  in  1  12 MHz system clock; single clock domain, all logic on its rising edge.
REQ-002 The block SHALL have the port iRst  in  1  reset; synchronous, active-high.
REQ-003 The block SHALL have the port iStart  in  1  load request, sampled only in IDLE.
REQ-004 The block SHALL have the port iTapCnt  in  6  number of taps to be supplied; legal range 1..40; sampled with iStart.
REQ-005 The block SHALL have the port iCoeffValid  in  1  coefficient word valid.
REQ-006 The block SHALL have the port iCoeffData  in  16  coefficient word, two's complement.
REQ-007 The block SHALL have the port oCoeffReady  out  1  loader accepts a word this cycle.
REQ-008 The block SHALL have the port oCoeffUpdateFlag  out  1  drives the FIR iCoeffUpdateFlag; high while a load is in progress.
REQ-009 The block SHALL have the port oCsnRam  out  1  RAM chip select, active-low.
REQ-010 The block SHALL have the port oWrnRam  out  1  RAM write enable, active-low.
REQ-011 The block SHALL have the port oAddrRam  out  6  RAM address.
REQ-012 The block SHALL have the port oWrDtRam  out  16  RAM write data.
REQ-013 The block SHALL have the port oBusy  out  1  state is not IDLE.
REQ-014 The block SHALL have the port oDone  out  1  one-cycle pulse when a load completes.
REQ-015 The block SHALL have the port oErr  out  1  one-cycle pulse when iTapCnt is illegal.

Function
REQ-016 States SHALL be IDLE, WAIT_DATA, WRITE, RELEASE, ZFILL, DONE; all outputs SHALL be registered.
REQ-017 The block SHALL leave IDLE as follows:
- iStart=1 with iTapCnt in 1..40 -> WAIT_DATA next edge; latch iTapCnt; clear index to 0; oCoeffUpdateFlag=1 from that edge.
- iStart=1 with iTapCnt of 0 or >40 -> oErr=1 for one cycle; stay IDLE; no RAM access; flag stays 0.
REQ-018 oCoeffReady SHALL be 1 only in WAIT_DATA; a word SHALL transfer on an edge where iCoeffValid=1 and oCoeffReady=1, latching data into oWrDtRam and entering WRITE.
REQ-019 In WAIT_DATA with iCoeffValid=0 the block SHALL wait indefinitely with no timeout and no RAM access.
REQ-020 In WRITE, oCsnRam=0 and oWrnRam=0 SHALL hold for exactly one cycle, with oAddrRam and oWrDtRam stable.
REQ-021 In RELEASE, oCsnRam=1 and oWrnRam=1 SHALL hold for one cycle, with address and data held.
REQ-022 The address map for index i (0..39) SHALL be oAddrRam = 16*(i/10) + (i mod 10):
- i=0..9 -> 0..9
- i=10..19 -> 16..25
- i=20..29 -> 32..41
- i=30..39 -> 48..57
REQ-023 After RELEASE the next state SHALL be selected as follows:
- index < tapcnt-1 -> increment index, return to WAIT_DATA.
- index = tapcnt-1 and index < 39 -> increment index, enter ZFILL.
- index = 39 -> DONE.
REQ-024 ZFILL SHALL drive oWrDtRam=0 and perform the same WRITE/RELEASE 2-cycle pattern per index, without handshaking, up to index 39 inclusive; then DONE.
REQ-025 Throughput SHALL be 3 cycles per supplied word (WAIT_DATA, WRITE, RELEASE) when iCoeffValid is held high, and 2 cycles per zero-filled index.
REQ-026 Every load SHALL therefore write exactly 40 RAM locations.
REQ-027 In DONE, oDone=1 and oCoeffUpdateFlag=0 SHALL hold for one cycle; next state SHALL be IDLE.
REQ-028 iStart outside IDLE SHALL be ignored, with no restart and no error.
REQ-029 Index and address arithmetic SHALL be unsigned 6-bit; data SHALL pass through unmodified and uncapped.

Reset
REQ-030 iRst=1 at a rising edge SHALL force, from that edge: state IDLE, index 0, oCsnRam=1, oWrnRam=1, oAddrRam=0, oWrDtRam=0, oCoeffReady=0, oCoeffUpdateFlag=0, oBusy=0, oDone=0, oErr=0.
REQ-031 iRst SHALL take priority over all other inputs, including mid-WRITE; a partially completed load SHALL NOT be resumed.

Verification
REQ-032 The bench SHALL cover: iTapCnt=33, 33 words with valid held high -> 33 writes at the mapped addresses (index 16 -> addr 22, index 32 -> addr 50), then 7 zero writes at 51..57, then a single oDone pulse; total 33*3+7*2 cycles from first ready to DONE.
REQ-033 The bench SHALL cover: iTapCnt=40 with valid toggling 1/0 randomly -> no write while valid=0; data at each address equals the word sent; no ZFILL; oDone once.
REQ-034 The bench SHALL cover: iTapCnt=0 and iTapCnt=41 -> one-cycle oErr each, oBusy stays 0, oCsnRam stays 1.
REQ-035 The bench SHALL cover: iRst asserted in the WRITE cycle of index 12 -> next edge shows all outputs at reset values; a new iStart performs a full 40-location load from index 0.
REQ-036 The bench SHALL cover: iStart pulsed during WAIT_DATA and during ZFILL -> ignored; the write sequence and addresses are unchanged.
REQ-037 The bench SHALL cover: word 0xEF0E (-4338) -> oWrDtRam=0xEF0E during its WRITE cycle, with oCsnRam/oWrnRam low for exactly one cycle.
